// File: rtl/decode_queue_pkg.sv
// Shared decode definitions: ALU codes, opcode/funct constants, class codes, bundle type.
package decode_queue_pkg;

   // ALU operation codes
   localparam logic [4:0] ALU_UNUSED = 5'd0;
   localparam logic [4:0] ALU_ADD    = 5'd1;
   localparam logic [4:0] ALU_SUB    = 5'd2;
   localparam logic [4:0] ALU_SLL    = 5'd3;
   localparam logic [4:0] ALU_SLT    = 5'd4;
   localparam logic [4:0] ALU_SLTU   = 5'd5;
   localparam logic [4:0] ALU_XOR    = 5'd6;
   localparam logic [4:0] ALU_SRL    = 5'd7;
   localparam logic [4:0] ALU_SRA    = 5'd8;
   localparam logic [4:0] ALU_OR     = 5'd9;
   localparam logic [4:0] ALU_AND    = 5'd10;
   localparam logic [4:0] ALU_MUL    = 5'd11;
   localparam logic [4:0] ALU_MULH   = 5'd12;
   localparam logic [4:0] ALU_MULHSU = 5'd13;
   localparam logic [4:0] ALU_MULHU  = 5'd14;
   localparam logic [4:0] ALU_DIV    = 5'd15;
   localparam logic [4:0] ALU_DIVU   = 5'd16;
   localparam logic [4:0] ALU_REM    = 5'd17;
   localparam logic [4:0] ALU_REMU   = 5'd18;

   // Major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct7 values
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   // Load / store / branch class codes
   localparam logic [2:0] LD_NOT = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                          LD_LBU = 3'd4, LD_LHU = 3'd5;
   localparam logic [1:0] ST_NOT = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
   // JAL and JALR share the unconditional-jump class
   localparam logic [2:0] BR_NOT = 3'd0, BR_JAL = 3'd1, BR_EQ = 3'd2, BR_NE = 3'd3,
                          BR_LT = 3'd4, BR_GE = 3'd5, BR_LTU = 3'd6, BR_GEU = 3'd7;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  alucode;
      logic        using_r2;
      logic        using_pc;
      logic        write_reg;
      logic [2:0]  info_load;
      logic [1:0]  info_store;
      logic [2:0]  info_branch;
      logic        illegal;
   } dec_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle of the decode queue.
interface decode_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_ir;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  srcreg1_num;
   logic [4:0]  srcreg2_num;
   logic [4:0]  dstreg_num;
   logic [31:0] imm;
   logic [4:0]  alucode;
   logic        using_r2;
   logic        using_pc;
   logic        write_reg;
   logic [2:0]  info_load;
   logic [1:0]  info_store;
   logic [2:0]  info_branch;
   logic        illegal;

   modport slave (
      input  in_valid, in_ir, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num,
             imm, alucode, using_r2, using_pc, write_reg, info_load, info_store,
             info_branch, illegal
   );

   modport master (
      output in_valid, in_ir, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, srcreg1_num, srcreg2_num, dstreg_num,
             imm, alucode, using_r2, using_pc, write_reg, info_load, info_store,
             info_branch, illegal
   );
endinterface

// File: rtl/decode_queue_decode_logic.sv
// Single-cycle RV32I (optionally RV32M) instruction decoder.
module decode_logic
   import decode_queue_pkg::*;
#(
   parameter bit ENABLE_M = 1'b0
) (
   input  logic [31:0] ir,
   output dec_t        dec
);

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1_f;
   logic [4:0]  rs2_f;
   logic [4:0]  rd_f;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] shamt;
   logic        bad;

   assign opcode = ir[6:0];
   assign rd_f   = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1_f  = ir[19:15];
   assign rs2_f  = ir[24:20];
   assign funct7 = ir[31:25];
   assign imm_i  = {{20{ir[31]}}, ir[31:20]};
   assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u  = {ir[31:12], 12'b0};
   assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign shamt  = {27'b0, ir[24:20]};

   // Field extraction per format; any unrecognised encoding collapses to an all-zero illegal bundle
   always_comb begin
      dec = '0;
      bad = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec.rd = rd_f; dec.imm = imm_u; dec.alucode = ALU_UNUSED; dec.write_reg = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rd = rd_f; dec.imm = imm_u; dec.alucode = ALU_ADD;
            dec.using_pc = 1'b1; dec.write_reg = 1'b1;
         end
         OPC_JAL: begin
            dec.rd = rd_f; dec.imm = imm_j; dec.alucode = ALU_ADD;
            dec.using_pc = 1'b1; dec.write_reg = 1'b1; dec.info_branch = BR_JAL;
         end
         OPC_JALR: begin
            dec.rs1 = rs1_f; dec.rd = rd_f; dec.imm = imm_i; dec.alucode = ALU_ADD;
            dec.write_reg = 1'b1; dec.info_branch = BR_JAL;
            bad = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_b; dec.alucode = ALU_ADD;
            dec.using_pc = 1'b1;
            case (funct3)
               3'd0: dec.info_branch = BR_EQ;
               3'd1: dec.info_branch = BR_NE;
               3'd4: dec.info_branch = BR_LT;
               3'd5: dec.info_branch = BR_GE;
               3'd6: dec.info_branch = BR_LTU;
               3'd7: dec.info_branch = BR_GEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.rs1 = rs1_f; dec.rd = rd_f; dec.imm = imm_i; dec.alucode = ALU_ADD;
            dec.write_reg = 1'b1;
            case (funct3)
               3'd0: dec.info_load = LD_LB;
               3'd1: dec.info_load = LD_LH;
               3'd2: dec.info_load = LD_LW;
               3'd4: dec.info_load = LD_LBU;
               3'd5: dec.info_load = LD_LHU;
               default: bad = 1'b1;
            endcase
         end
         OPC_STORE: begin
            dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.imm = imm_s; dec.alucode = ALU_ADD;
            case (funct3)
               3'd0: dec.info_store = ST_SB;
               3'd1: dec.info_store = ST_SH;
               3'd2: dec.info_store = ST_SW;
               default: bad = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            dec.rs1 = rs1_f; dec.rd = rd_f; dec.imm = imm_i; dec.write_reg = 1'b1;
            case (funct3)
               3'd0: dec.alucode = ALU_ADD;
               3'd2: dec.alucode = ALU_SLT;
               3'd3: dec.alucode = ALU_SLTU;
               3'd4: dec.alucode = ALU_XOR;
               3'd6: dec.alucode = ALU_OR;
               3'd7: dec.alucode = ALU_AND;
               3'd1: begin
                  dec.alucode = ALU_SLL; dec.imm = shamt;
                  bad = (funct7 != F7_BASE);
               end
               default: begin
                  dec.imm = shamt;
                  if (funct7 == F7_BASE)     dec.alucode = ALU_SRL;
                  else if (funct7 == F7_ALT) dec.alucode = ALU_SRA;
                  else                       bad = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            dec.rs1 = rs1_f; dec.rs2 = rs2_f; dec.rd = rd_f;
            dec.using_r2 = 1'b1; dec.write_reg = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  3'd0: dec.alucode = ALU_ADD;
                  3'd1: dec.alucode = ALU_SLL;
                  3'd2: dec.alucode = ALU_SLT;
                  3'd3: dec.alucode = ALU_SLTU;
                  3'd4: dec.alucode = ALU_XOR;
                  3'd5: dec.alucode = ALU_SRL;
                  3'd6: dec.alucode = ALU_OR;
                  default: dec.alucode = ALU_AND;
               endcase
            end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
               dec.alucode = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
               dec.alucode = ALU_SRA;
            end else if (ENABLE_M && funct7 == F7_MULDIV) begin
               case (funct3)
                  3'd0: dec.alucode = ALU_MUL;
                  3'd1: dec.alucode = ALU_MULH;
                  3'd2: dec.alucode = ALU_MULHSU;
                  3'd3: dec.alucode = ALU_MULHU;
                  3'd4: dec.alucode = ALU_DIV;
                  3'd5: dec.alucode = ALU_DIVU;
                  3'd6: dec.alucode = ALU_REM;
                  default: dec.alucode = ALU_REMU;
               endcase
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         dec = '0;
         dec.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/decode_queue.sv
// Instruction FIFO feeding a registered decode stage with valid/ready on both sides.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   decode_queue_if.slave  q
);

   localparam int PW = $clog2(DEPTH);

   logic [31:0]   ir_mem_q [DEPTH];
   logic [31:0]   ir_mem_d [DEPTH];
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_pc_q, out_pc_d;
   dec_t          dec_q, dec_d;
   dec_t          head_dec;
   logic          in_ready;
   logic          push;
   logic          pop;

   assign in_ready = (count_q < (PW + 1)'(DEPTH));
   assign push     = q.in_valid && in_ready;
   assign pop      = (count_q != '0) && (!out_valid_q || q.out_ready);

   decode_logic #(.ENABLE_M(ENABLE_M)) u_decode (
      .ir  (ir_mem_q[rd_ptr_q]),
      .dec (head_dec)
   );

   // Next-state: flush wins over push/pop; otherwise push at tail, pop head into output register
   always_comb begin
      ir_mem_d    = ir_mem_q;
      pc_mem_d    = pc_mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_pc_d    = out_pc_q;
      dec_d       = dec_q;
      if (q.flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            ir_mem_d[wr_ptr_q] = q.in_ir;
            pc_mem_d[wr_ptr_q] = q.in_pc;
            wr_ptr_d           = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            dec_d       = head_dec;
            out_pc_d    = pc_mem_q[rd_ptr_q];
            out_valid_d = 1'b1;
         end else if (q.out_ready) begin
            out_valid_d = 1'b0;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control and output bundle registers; reset clears them asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         dec_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         dec_q       <= dec_d;
      end
   end

   // Queue storage; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      ir_mem_q <= ir_mem_d;
      pc_mem_q <= pc_mem_d;
   end

   assign q.in_ready    = in_ready;
   assign q.out_valid   = out_valid_q;
   assign q.out_pc      = out_pc_q;
   assign q.srcreg1_num = dec_q.rs1;
   assign q.srcreg2_num = dec_q.rs2;
   assign q.dstreg_num  = dec_q.rd;
   assign q.imm         = dec_q.imm;
   assign q.alucode     = dec_q.alucode;
   assign q.using_r2    = dec_q.using_r2;
   assign q.using_pc    = dec_q.using_pc;
   assign q.write_reg   = dec_q.write_reg;
   assign q.info_load   = dec_q.info_load;
   assign q.info_store  = dec_q.info_store;
   assign q.info_branch = dec_q.info_branch;
   assign q.illegal     = dec_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode table plus backpressure, flush and reset sequences.
module tb_decode_queue;
   import decode_queue_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   decode_queue_if bus ();
   decode_queue_if bus0 ();

   assign bus0.in_valid  = bus.in_valid;
   assign bus0.in_ir     = bus.in_ir;
   assign bus0.in_pc     = bus.in_pc;
   assign bus0.flush     = bus.flush;
   assign bus0.out_ready = bus.out_ready;

   decode_queue #(.DEPTH(4), .ENABLE_M(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .q(bus.slave));
   decode_queue #(.DEPTH(4), .ENABLE_M(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .q(bus0.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [4:0]  alu;
      logic        r2;
      logic        upc;
      logic        wr;
      logic [2:0]  ld;
      logic [1:0]  st;
      logic [2:0]  br;
      logic        ill;
      logic        ill0;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] addi_x1(input int k);
      logic [11:0] im;
      im = 12'(k);
      return {im, 20'h00093};
   endfunction

   initial begin
      int acc;
      logic took;
      checks = 0;
      errors = 0;

      vecs[0]  = '{32'h00b50633, 32'h100, 5'd10, 5'd11, 5'd12, 32'h0,        ALU_ADD,    1'b1, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[1]  = '{32'hfec584e3, 32'h104, 5'd11, 5'd12, 5'd0,  32'hffffffe8, ALU_ADD,    1'b0, 1'b1, 1'b0, LD_NOT, ST_NOT, BR_EQ,  1'b0, 1'b0};
      vecs[2]  = '{32'h008000ef, 32'h108, 5'd0,  5'd0,  5'd1,  32'h8,        ALU_ADD,    1'b0, 1'b1, 1'b1, LD_NOT, ST_NOT, BR_JAL, 1'b0, 1'b0};
      vecs[3]  = '{32'h02b50633, 32'h10c, 5'd10, 5'd11, 5'd12, 32'h0,        ALU_MUL,    1'b1, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b1};
      vecs[4]  = '{32'h123452b7, 32'h110, 5'd0,  5'd0,  5'd5,  32'h12345000, ALU_UNUSED, 1'b0, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[5]  = '{32'hffc12303, 32'h114, 5'd2,  5'd0,  5'd6,  32'hfffffffc, ALU_ADD,    1'b0, 1'b0, 1'b1, LD_LW,  ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[6]  = '{32'h0071a423, 32'h118, 5'd3,  5'd7,  5'd0,  32'h8,        ALU_ADD,    1'b0, 1'b0, 1'b0, LD_NOT, ST_SW,  BR_NOT, 1'b0, 1'b0};
      vecs[7]  = '{32'h00000073, 32'h11c, 5'd0,  5'd0,  5'd0,  32'h0,        ALU_UNUSED, 1'b0, 1'b0, 1'b0, LD_NOT, ST_NOT, BR_NOT, 1'b1, 1'b1};
      vecs[8]  = '{32'h4034d413, 32'h120, 5'd9,  5'd0,  5'd8,  32'h3,        ALU_SRA,    1'b0, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[9]  = '{32'hfff00093, 32'h124, 5'd0,  5'd0,  5'd1,  32'hffffffff, ALU_ADD,    1'b0, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[10] = '{32'h00008067, 32'h128, 5'd1,  5'd0,  5'd0,  32'h0,        ALU_ADD,    1'b0, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_JAL, 1'b0, 1'b0};
      vecs[11] = '{32'h405201b3, 32'h12c, 5'd4,  5'd5,  5'd3,  32'h0,        ALU_SUB,    1'b1, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};
      vecs[12] = '{32'h02c5d533, 32'h130, 5'd11, 5'd12, 5'd10, 32'h0,        ALU_DIVU,   1'b1, 1'b0, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b1};
      vecs[13] = '{32'h00001117, 32'h134, 5'd0,  5'd0,  5'd2,  32'h1000,     ALU_ADD,    1'b0, 1'b1, 1'b1, LD_NOT, ST_NOT, BR_NOT, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_ir     = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset in_ready",  32'(bus.in_ready),  32'd1);
      chk("reset alucode",   32'(bus.alucode),   32'd0);
      chk("reset imm",       bus.imm,            32'd0);
      chk("reset illegal",   32'(bus.illegal),   32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // decode table, one instruction at a time with out_ready high
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_ir     = vecs[i].ir;
         bus.in_pc     = vecs[i].pc;
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("v%0d out_pc", i), bus.out_pc, vecs[i].pc);
         chk($sformatf("v%0d rs1", i), 32'(bus.srcreg1_num), 32'(vecs[i].rs1));
         chk($sformatf("v%0d rs2", i), 32'(bus.srcreg2_num), 32'(vecs[i].rs2));
         chk($sformatf("v%0d rd", i), 32'(bus.dstreg_num), 32'(vecs[i].rd));
         chk($sformatf("v%0d imm", i), bus.imm, vecs[i].imm);
         chk($sformatf("v%0d alucode", i), 32'(bus.alucode), 32'(vecs[i].alu));
         chk($sformatf("v%0d using_r2", i), 32'(bus.using_r2), 32'(vecs[i].r2));
         chk($sformatf("v%0d using_pc", i), 32'(bus.using_pc), 32'(vecs[i].upc));
         chk($sformatf("v%0d write_reg", i), 32'(bus.write_reg), 32'(vecs[i].wr));
         chk($sformatf("v%0d info_load", i), 32'(bus.info_load), 32'(vecs[i].ld));
         chk($sformatf("v%0d info_store", i), 32'(bus.info_store), 32'(vecs[i].st));
         chk($sformatf("v%0d info_branch", i), 32'(bus.info_branch), 32'(vecs[i].br));
         chk($sformatf("v%0d illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
         chk($sformatf("v%0d noM illegal", i), 32'(bus0.illegal), 32'(vecs[i].ill0));
         chk($sformatf("v%0d noM write_reg", i), 32'(bus0.write_reg),
             32'(vecs[i].ill0 ? 1'b0 : vecs[i].wr));
      end

      // backpressure: fill queue plus output register, then drain in order
      @(negedge clk);
      bus.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = 1'b1;
         bus.in_ir    = addi_x1(acc);
         bus.in_pc    = 32'h200 + 32'(acc) * 4;
         took         = bus.in_ready;
         @(negedge clk);
         if (took) acc++;
      end
      bus.in_valid = 1'b0;
      chk("fill accepted", 32'(acc), 32'd5);
      chk("fill in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall imm held", bus.imm, 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("drain%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         chk($sformatf("drain%0d imm", i), bus.imm, 32'(i));
         chk($sformatf("drain%0d out_pc", i), bus.out_pc, 32'h200 + 32'(i) * 4);
         @(negedge clk);
      end
      chk("drain empty out_valid", 32'(bus.out_valid), 32'd0);

      // flush with three queued entries and a push offered in the flush cycle
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_ir    = addi_x1(16 + i);
         bus.in_pc    = 32'h300 + 32'(i) * 4;
         @(negedge clk);
      end
      chk("preflush count", 32'(dut.count_q), 32'd3);
      chk("preflush out_valid", 32'(bus.out_valid), 32'd1);
      bus.flush = 1'b1;
      bus.in_ir = addi_x1(2047);
      bus.in_pc = 32'h3f0;
      @(negedge clk);
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush count", 32'(dut.count_q), 32'd0);
      chk("flush in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ir     = addi_x1(85);
      bus.in_pc     = 32'h400;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("postflush out_valid", 32'(bus.out_valid), 32'd1);
      chk("postflush imm", bus.imm, 32'd85);
      chk("postflush out_pc", bus.out_pc, 32'h400);
      @(negedge clk);
      chk("postflush empty", 32'(bus.out_valid), 32'd0);

      // asynchronous reset in the middle of a stalled stream
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.in_valid = 1'b1;
         bus.in_ir    = addi_x1(49 + i);
         bus.in_pc    = 32'h500 + 32'(i) * 4;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("prereset out_valid", 32'(bus.out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
      chk("async reset imm", bus.imm, 32'd0);
      chk("async reset rd", 32'(bus.dstreg_num), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("postreset in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_ir     = addi_x1(119);
      bus.in_pc     = 32'h600;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("postreset out_valid", 32'(bus.out_valid), 32'd1);
      chk("postreset imm", bus.imm, 32'd119);
      chk("postreset out_pc", bus.out_pc, 32'h600);
      @(negedge clk);
      chk("postreset empty", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
